half_duplex_spi_slave: RTL and testbench
========================================

HALF_DUPLEX_SPI_SLAVE -- requirements
Module: half_duplex_spi_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving data-phase bits per word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, giving address bits; command phase = 1+ADDR_WIDTH bits.
REQ-003 SHALL have port fabric_clk, input, 1 bit: the sole clock, at least 8x the SPI clock rate.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports spi_cpol and spi_cpha, inputs, 1 bit each: SPI mode, captured only while the frame is idle.
REQ-006 SHALL have ports spi_sclk and spi_cs_n, inputs, 1 bit each: asynchronous to fabric_clk.
REQ-007 SHALL have port spi_sdio, inout, 1 bit: the shared data line.
REQ-008 SHALL have ports reg_addr (out, ADDR_WIDTH), reg_wdata (out, DATA_WIDTH), reg_wr_en (out, 1) and reg_rd_en (out, 1): the register-bus request.
REQ-009 SHALL have port reg_rdata, input, DATA_WIDTH: valid one cycle after reg_rd_en.
REQ-010 SHALL have outputs busy (1 bit: frame active) and frame_error (1 bit: one-cycle pulse).

Function
REQ-011 SHALL pass spi_sclk, spi_cs_n and spi_sdio through 2-FF synchronizers, then detect edges with one further register stage.
REQ-012 SHALL define the leading edge as the first edge leaving spi_cpol; sample on the leading edge if CPHA=0, else on the trailing edge; shift out on the opposite edge.
REQ-013 SHALL use states IDLE, CMD, FETCH, READ_DATA, WRITE_DATA, COMMIT and WAIT_CS.
REQ-014 IDLE: SHALL latch cpol/cpha and, on the synchronized cs_n falling edge, go to CMD with the bit counter loaded to 1+ADDR_WIDTH.
REQ-015 CMD: SHALL sample bits MSB-first; the first bit is rw (1=read), the remainder are the address.
REQ-016 CMD exit: on the last command bit, write SHALL go to WRITE_DATA; read SHALL go to FETCH, pulsing reg_rd_en for 1 cycle.
REQ-017 FETCH: SHALL load reg_rdata into the shift register one cycle after reg_rd_en, drive its MSB onto spi_sdio, and go to READ_DATA.
REQ-018 READ_DATA: SHALL shift out on each shift edge; after DATA_WIDTH sample edges SHALL go to WAIT_CS.
REQ-019 FETCH plus first-bit drive SHALL complete within 3 fabric_clk cycles of the last command sample, meeting half an SCLK period at 8x oversampling.
REQ-020 WRITE_DATA: SHALL sample DATA_WIDTH bits MSB-first, then go to COMMIT.
REQ-021 COMMIT: SHALL pulse reg_wr_en for exactly 1 cycle with reg_addr/reg_wdata stable, then go to WAIT_CS.
REQ-022 spi_sdio SHALL be driven only in FETCH-drive/READ_DATA with cs_n low, and SHALL be high-Z in all other states.
REQ-023 WAIT_CS: SHALL ignore SCLK edges and return to IDLE on cs_n rising.
REQ-024 cs_n rising in CMD, FETCH, READ_DATA or WRITE_DATA SHALL pulse frame_error, suppress reg_wr_en, release sdio and return to IDLE.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 reg_rd_en and reg_wr_en SHALL never be asserted in the same cycle.

Reset
REQ-027 reset_n low SHALL immediately tri-state spi_sdio and clear every output: reg_* = 0, busy = 0, frame_error = 0, state = IDLE.
REQ-028 Reset mid-frame SHALL discard the frame; after release the block SHALL wait in IDLE for a fresh cs_n falling edge.

Configuration
REQ-029 With HALF_DUPLEX_SPI_SLAVE_BURST_EN defined: after a data word, if cs_n is still low, SHALL increment reg_addr (wrapping 2^ADDR_WIDTH-1 to 0) and continue with FETCH (read) or WRITE_DATA (write) instead of WAIT_CS.
REQ-030 Without the macro: SHALL handle a single word per frame; any further clocks are ignored in WAIT_CS.

Structure
REQ-031 Package half_duplex_spi_slave_pkg SHALL hold the state enum and the command-field constants (RW bit position, command length).
REQ-032 Sub-module signal_synchronizer (2-FF, reset value parameterized) SHALL be instantiated for sclk (reset value = cpol), cs_n (reset value 1) and sdio.

Verification
REQ-033 Mode 0, write, cmd 0x05, data 0xDEADBEEF -> one reg_wr_en pulse with addr 0x05, wdata 0xDEADBEEF; sdio never driven.
REQ-034 Mode 3, read, cmd 0x85, reg_rdata 0xA5A5_0F0F -> master captures 0xA5A50F0F; one reg_rd_en pulse; sdio high-Z after cs_n rises.
REQ-035 Modes 1 and 2, write/read round trip at addr 0x7F with SCLK = fabric_clk/8 -> data matches; no frame_error.
REQ-036 cs_n raised after 20 of 32 write data bits -> frame_error pulses once; no reg_wr_en; next frame succeeds.
REQ-037 reset_n asserted during READ_DATA -> sdio high-Z in the same cycle; all outputs 0; busy stays 0 until next cs_n fall.
REQ-038 BURST_EN, write of 2 words starting at addr 0x7F -> reg_wr_en pulses at addr 0x7F then 0x00; without macro, only 0x7F is written.

Source files
------------

// File: rtl/half_duplex_spi_slave_pkg.sv
// Shared FSM state encodings and command-field helpers for the half-duplex SPI slave.
package half_duplex_spi_slave_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CMD        = 3'd1;
    localparam logic [2:0] ST_FETCH      = 3'd2;
    localparam logic [2:0] ST_READ_DATA  = 3'd3;
    localparam logic [2:0] ST_WRITE_DATA = 3'd4;
    localparam logic [2:0] ST_COMMIT     = 3'd5;
    localparam logic [2:0] ST_WAIT_CS    = 3'd6;

    // Command word is rw followed by the address, rw sent first (MSB).
    function automatic int cmd_len(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int rw_bit_pos(input int addr_width);
        return addr_width;
    endfunction

endpackage

// File: rtl/half_duplex_spi_slave_signal_synchronizer.sv
// Two-flop synchronizer with a reset value supplied by the instantiating block.
module signal_synchronizer (
    input  logic fabric_clk,
    input  logic reset_n,
    input  logic i_rst_val,
    input  logic i_async,
    output logic o_sync
);
    logic [1:0] r_meta;

    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) r_meta <= {2{i_rst_val}};
        else          r_meta <= {r_meta[0], i_async};
    end

    assign o_sync = r_meta[1];

endmodule

// File: rtl/half_duplex_spi_slave.sv
// 3-wire half-duplex SPI slave bridging a master onto a simple register bus.
// Define HALF_DUPLEX_SPI_SLAVE_BURST_EN to keep transferring at incrementing addresses while cs_n stays low.
module half_duplex_spi_slave
    import half_duplex_spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  fabric_clk,
    input  logic                  reset_n,
    input  logic                  spi_cpol,
    input  logic                  spi_cpha,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    inout  wire                   spi_sdio,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic                  frame_error
);
    localparam int CMD_LEN = cmd_len(ADDR_WIDTH);
    localparam int RW_POS  = rw_bit_pos(ADDR_WIDTH);
    localparam int CNT_W   = $clog2((CMD_LEN > DATA_WIDTH ? CMD_LEN : DATA_WIDTH) + 1);
`ifdef HALF_DUPLEX_SPI_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic w_sclk_s, w_cs_s, w_sdio_s;
    logic r_sclk_d, r_cs_d, r_armed;
    logic [1:0] r_live;
    logic [2:0] r_state;
    logic r_cpol, r_cpha, r_oe, r_skip, r_wr_en, r_rd_en, r_ferr;
    logic [CNT_W-1:0]      r_cnt;
    logic [CMD_LEN-2:0]    r_cmd;
    logic [DATA_WIDTH-1:0] r_shift, r_wdata;
    logic [ADDR_WIDTH-1:0] r_addr;

    signal_synchronizer u_sync_sclk (.fabric_clk(fabric_clk), .reset_n(reset_n), .i_rst_val(spi_cpol),
                                     .i_async(spi_sclk), .o_sync(w_sclk_s));
    signal_synchronizer u_sync_cs   (.fabric_clk(fabric_clk), .reset_n(reset_n), .i_rst_val(1'b1),
                                     .i_async(spi_cs_n), .o_sync(w_cs_s));
    signal_synchronizer u_sync_sdio (.fabric_clk(fabric_clk), .reset_n(reset_n), .i_rst_val(1'b0),
                                     .i_async(spi_sdio), .o_sync(w_sdio_s));

    logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift, w_cs_fall, w_active;
    logic [CMD_LEN-1:0] w_cmd_next;
    logic [DATA_WIDTH-1:0] w_wr_next;
    assign w_rise     = w_sclk_s & ~r_sclk_d;
    assign w_fall     = ~w_sclk_s & r_sclk_d;
    assign w_lead     = r_cpol ? w_fall : w_rise;
    assign w_trail    = r_cpol ? w_rise : w_fall;
    assign w_sample   = r_cpha ? w_trail : w_lead;
    assign w_shift    = r_cpha ? w_lead : w_trail;
    assign w_cs_fall  = ~w_cs_s & r_cs_d;
    assign w_cmd_next = {r_cmd, w_sdio_s};
    assign w_wr_next  = {r_shift[DATA_WIDTH-2:0], w_sdio_s};
    assign w_active   = (r_state == ST_CMD) || (r_state == ST_FETCH) ||
                        (r_state == ST_READ_DATA) || (r_state == ST_WRITE_DATA);

    // A frame may only start after cs_n has been seen high through a settled synchronizer,
    // so a reset released mid-frame cannot fake a falling edge.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_d <= spi_cpol;
            r_cs_d   <= 1'b1;
            r_live   <= 2'b00;
            r_armed  <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_cs_d   <= w_cs_s;
            r_live   <= {r_live[0], 1'b1};
            r_armed  <= r_armed | (r_live[1] & w_cs_s);
        end
    end

    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_oe    <= 1'b0;
            r_skip  <= 1'b0;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_ferr  <= 1'b0;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_shift <= '0;
            r_wdata <= '0;
            r_addr  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_ferr  <= 1'b0;
            if (w_active && w_cs_s) begin
                r_ferr  <= 1'b1;
                r_oe    <= 1'b0;
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cpol <= spi_cpol;
                        r_cpha <= spi_cpha;
                        r_oe   <= 1'b0;
                        if (w_cs_fall && r_armed) begin
                            r_cnt   <= CNT_W'(CMD_LEN);
                            r_state <= ST_CMD;
                        end
                    end
                    ST_CMD: if (w_sample) begin
                        r_cmd <= w_cmd_next[CMD_LEN-2:0];
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_addr <= w_cmd_next[ADDR_WIDTH-1:0];
                            if (w_cmd_next[RW_POS]) begin
                                r_rd_en <= 1'b1;
                                r_state <= ST_FETCH;
                            end else begin
                                r_cnt   <= CNT_W'(DATA_WIDTH);
                                r_state <= ST_WRITE_DATA;
                            end
                        end
                    end
                    // First cycle carries the rd_en pulse; reg_rdata is valid on the second.
                    ST_FETCH: if (!r_rd_en) begin
                        r_shift <= reg_rdata;
                        r_oe    <= 1'b1;
                        r_skip  <= 1'b1;
                        r_cnt   <= CNT_W'(DATA_WIDTH);
                        r_state <= ST_READ_DATA;
                    end
                    ST_READ_DATA: begin
                        // The MSB is already on the line, so the first shift edge only holds it.
                        if (w_shift) begin
                            if (r_skip) r_skip  <= 1'b0;
                            else        r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (w_sample) begin
                            r_cnt <= r_cnt - 1'b1;
                            if (r_cnt == CNT_W'(1)) begin
                                r_oe <= 1'b0;
                                if (BURST && !w_cs_s) begin
                                    r_addr  <= r_addr + 1'b1;
                                    r_rd_en <= 1'b1;
                                    r_state <= ST_FETCH;
                                end else begin
                                    r_state <= ST_WAIT_CS;
                                end
                            end
                        end
                    end
                    ST_WRITE_DATA: if (w_sample) begin
                        r_shift <= w_wr_next;
                        r_cnt   <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_wdata <= w_wr_next;
                            r_wr_en <= 1'b1;
                            r_state <= ST_COMMIT;
                        end
                    end
                    ST_COMMIT: begin
                        if (BURST && !w_cs_s) begin
                            r_addr  <= r_addr + 1'b1;
                            r_cnt   <= CNT_W'(DATA_WIDTH);
                            r_state <= ST_WRITE_DATA;
                        end else begin
                            r_state <= ST_WAIT_CS;
                        end
                    end
                    ST_WAIT_CS: if (w_cs_s) r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi_sdio    = (r_oe && !spi_cs_n) ? r_shift[DATA_WIDTH-1] : 1'bz;
    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;
    assign reg_wr_en   = r_wr_en;
    assign reg_rd_en   = r_rd_en;
    assign busy        = (r_state != ST_IDLE);
    assign frame_error = r_ferr;

endmodule

// File: tb/tb_half_duplex_spi_slave.sv
// Directed bench: bit-banged SPI master plus a small register-file model on the bus side.
module tb_half_duplex_spi_slave;
    logic fabric_clk = 1'b0;
    logic reset_n    = 1'b1;
    logic spi_cpol = 1'b0, spi_cpha = 1'b0, spi_sclk = 1'b0, spi_cs_n = 1'b1;
    logic m_oe = 1'b0, m_d = 1'b0;
    wire  spi_sdio;
    logic [6:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata = 32'h0;
    logic reg_wr_en, reg_rd_en, busy, frame_error;

    int total = 0, bad = 0;

    assign spi_sdio = m_oe ? m_d : 1'bz;
    pulldown (spi_sdio);

    always #5 fabric_clk = ~fabric_clk;

    half_duplex_spi_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) dut (
        .fabric_clk(fabric_clk), .reset_n(reset_n), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_sdio(spi_sdio), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata),
        .busy(busy), .frame_error(frame_error)
    );

    logic [31:0] mem [128];
    logic        use_ovr = 1'b0;
    logic [31:0] ovr     = 32'h0;
    int wr_n = 0, rd_n = 0, ferr_n = 0, both_n = 0;
    logic [6:0]  wa_q [$];
    logic [31:0] wd_q [$];
    logic [6:0]  ra_q [$];

    always @(posedge fabric_clk) begin
        if (reg_wr_en) begin
            mem[reg_addr] <= reg_wdata;
            wa_q.push_back(reg_addr);
            wd_q.push_back(reg_wdata);
            wr_n++;
        end
        if (reg_rd_en) begin
            reg_rdata <= use_ovr ? ovr : mem[reg_addr];
            ra_q.push_back(reg_addr);
            rd_n++;
        end
        if (frame_error) ferr_n++;
        if (reg_wr_en && reg_rd_en) both_n++;
    end

    task automatic half_sclk();
        repeat (4) @(negedge fabric_clk);
    endtask

    task automatic spi_frame(input bit pol, input bit pha, input int n_out, input logic [127:0] obits,
                             input int n_in, input int n_stop, input bit raise_cs, output logic [31:0] ibits);
        int n;
        n = n_out + n_in;
        if (n_stop < n) n = n_stop;
        ibits = '0;
        spi_cpol = pol; spi_cpha = pha; spi_sclk = pol;
        repeat (8) @(negedge fabric_clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge fabric_clk);
        for (int i = 0; i < n; i++) begin
            if (!pha) begin
                m_oe = (i < n_out);
                if (i < n_out) m_d = obits[n_out-1-i];
                half_sclk();
                if (i >= n_out) ibits = {ibits[30:0], spi_sdio};
                spi_sclk = ~pol;
                half_sclk();
                spi_sclk = pol;
            end else begin
                spi_sclk = ~pol;
                m_oe = (i < n_out);
                if (i < n_out) m_d = obits[n_out-1-i];
                half_sclk();
                if (i >= n_out) ibits = {ibits[30:0], spi_sdio};
                spi_sclk = pol;
                half_sclk();
            end
        end
        m_oe = 1'b0;
        if (raise_cs) begin
            half_sclk();
            spi_cs_n = 1'b1;
            repeat (8) @(negedge fabric_clk);
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge fabric_clk);
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (reg_wr_en !== 1'b0)   begin bad++; $display("FAIL rst_wr_en got=%b exp=0", reg_wr_en); end
        total++; if (reg_rd_en !== 1'b0)   begin bad++; $display("FAIL rst_rd_en got=%b exp=0", reg_rd_en); end
        total++; if (reg_addr !== 7'h00)   begin bad++; $display("FAIL rst_addr got=%h exp=00", reg_addr); end
        total++; if (reg_wdata !== 32'h0)  begin bad++; $display("FAIL rst_wdata got=%h exp=0", reg_wdata); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b exp=0", frame_error); end
        total++; if (spi_sdio !== 1'b0)    begin bad++; $display("FAIL rst_sdio got=%b exp=0(released)", spi_sdio); end
        reset_n = 1'b1;
        repeat (10) @(negedge fabric_clk);
    endtask

    task automatic test_mode0_write();
        int bw = wr_n, br = rd_n, bf = ferr_n, b = wa_q.size();
        logic [31:0] rx;
        spi_frame(0, 0, 40, {88'h0, 8'h05, 32'hDEADBEEF}, 0, 40, 1, rx);
        total++; if (wr_n - bw !== 1)        begin bad++; $display("FAIL m0w_wr_cnt got=%0d exp=1", wr_n - bw); end
        total++; if (wa_q[b] !== 7'h05)      begin bad++; $display("FAIL m0w_addr got=%h exp=05", wa_q[b]); end
        total++; if (wd_q[b] !== 32'hDEADBEEF) begin bad++; $display("FAIL m0w_data got=%h exp=deadbeef", wd_q[b]); end
        total++; if (rd_n - br !== 0)        begin bad++; $display("FAIL m0w_rd_cnt got=%0d exp=0", rd_n - br); end
        total++; if (ferr_n - bf !== 0)      begin bad++; $display("FAIL m0w_ferr got=%0d exp=0", ferr_n - bf); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL m0w_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mode3_read();
        int bw = wr_n, br = rd_n, bf = ferr_n, b = ra_q.size();
        logic [31:0] rx;
        use_ovr = 1'b1; ovr = 32'hA5A5_0F0F;
        spi_frame(1, 1, 8, {120'h0, 8'h85}, 32, 40, 1, rx);
        use_ovr = 1'b0;
        total++; if (rx !== 32'hA5A50F0F) begin bad++; $display("FAIL m3r_data got=%h exp=a5a50f0f", rx); end
        total++; if (rd_n - br !== 1)     begin bad++; $display("FAIL m3r_rd_cnt got=%0d exp=1", rd_n - br); end
        total++; if (ra_q[b] !== 7'h05)   begin bad++; $display("FAIL m3r_addr got=%h exp=05", ra_q[b]); end
        total++; if (wr_n - bw !== 0)     begin bad++; $display("FAIL m3r_wr_cnt got=%0d exp=0", wr_n - bw); end
        total++; if (ferr_n - bf !== 0)   begin bad++; $display("FAIL m3r_ferr got=%0d exp=0", ferr_n - bf); end
        total++; if (spi_sdio !== 1'b0)   begin bad++; $display("FAIL m3r_sdio_release got=%b exp=0(released)", spi_sdio); end
    endtask

    task automatic test_modes12();
        int bf = ferr_n;
        logic [31:0] rx;
        spi_frame(0, 1, 40, {88'h0, 8'h7F, 32'h1234_5678}, 0, 40, 1, rx);
        spi_frame(0, 1, 8, {120'h0, 8'hFF}, 32, 40, 1, rx);
        total++; if (rx !== 32'h12345678) begin bad++; $display("FAIL m1_roundtrip got=%h exp=12345678", rx); end
        spi_frame(1, 0, 40, {88'h0, 8'h7F, 32'hCAFE_F00D}, 0, 40, 1, rx);
        spi_frame(1, 0, 8, {120'h0, 8'hFF}, 32, 40, 1, rx);
        total++; if (rx !== 32'hCAFEF00D) begin bad++; $display("FAIL m2_roundtrip got=%h exp=cafef00d", rx); end
        total++; if (ra_q[ra_q.size()-1] !== 7'h7F) begin bad++; $display("FAIL m2_rd_addr got=%h exp=7f", ra_q[ra_q.size()-1]); end
        total++; if (ferr_n - bf !== 0)   begin bad++; $display("FAIL m12_ferr got=%0d exp=0", ferr_n - bf); end
    endtask

    task automatic test_abort();
        int bw = wr_n, bf = ferr_n, b;
        logic [31:0] rx;
        spi_frame(0, 0, 40, {88'h0, 8'h0A, 32'h5555_AAAA}, 0, 28, 1, rx);
        total++; if (ferr_n - bf !== 1) begin bad++; $display("FAIL abort_ferr got=%0d exp=1", ferr_n - bf); end
        total++; if (wr_n - bw !== 0)   begin bad++; $display("FAIL abort_wr_cnt got=%0d exp=0", wr_n - bw); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        b = wa_q.size();
        spi_frame(0, 0, 40, {88'h0, 8'h11, 32'h0BAD_F00D}, 0, 40, 1, rx);
        total++; if (wr_n - bw !== 1)          begin bad++; $display("FAIL abort_next_cnt got=%0d exp=1", wr_n - bw); end
        total++; if (wa_q[b] !== 7'h11)        begin bad++; $display("FAIL abort_next_addr got=%h exp=11", wa_q[b]); end
        total++; if (wd_q[b] !== 32'h0BADF00D) begin bad++; $display("FAIL abort_next_data got=%h exp=0badf00d", wd_q[b]); end
    endtask

    task automatic test_reset_mid_read();
        int bw, bf, b;
        logic [31:0] rx;
        use_ovr = 1'b1; ovr = 32'hA5A5_0F0F;
        spi_frame(0, 0, 8, {120'h0, 8'h85}, 32, 9, 0, rx);
        use_ovr = 1'b0;
        total++; if (rx[0] !== 1'b1) begin bad++; $display("FAIL rmr_first_bit got=%b exp=1", rx[0]); end
        @(negedge fabric_clk);
        total++; if (spi_sdio !== 1'b1) begin bad++; $display("FAIL rmr_driving got=%b exp=1", spi_sdio); end
        bf = ferr_n;
        reset_n = 1'b0;
        #1;
        total++; if (spi_sdio !== 1'b0)  begin bad++; $display("FAIL rmr_sdio got=%b exp=0(released)", spi_sdio); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rmr_busy got=%b exp=0", busy); end
        total++; if (reg_addr !== 7'h00) begin bad++; $display("FAIL rmr_addr got=%h exp=00", reg_addr); end
        repeat (3) @(negedge fabric_clk);
        reset_n = 1'b1;
        repeat (12) @(negedge fabric_clk);
        for (int k = 0; k < 6; k++) begin
            spi_sclk = ~spi_sclk;
            half_sclk();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmr_busy_after got=%b exp=0", busy); end
        spi_cs_n = 1'b1; spi_sclk = 1'b0;
        repeat (8) @(negedge fabric_clk);
        total++; if (ferr_n - bf !== 0) begin bad++; $display("FAIL rmr_ferr got=%0d exp=0", ferr_n - bf); end
        bw = wr_n; b = wa_q.size();
        spi_frame(0, 0, 40, {88'h0, 8'h22, 32'h3C3C_1234}, 0, 40, 1, rx);
        total++; if (wr_n - bw !== 1)          begin bad++; $display("FAIL rmr_next_cnt got=%0d exp=1", wr_n - bw); end
        total++; if (wd_q[b] !== 32'h3C3C1234) begin bad++; $display("FAIL rmr_next_data got=%h exp=3c3c1234", wd_q[b]); end
    endtask

    task automatic test_back_to_back();
        int bw = wr_n, b = wa_q.size(), exp_n;
        logic [31:0] rx;
`ifdef HALF_DUPLEX_SPI_SLAVE_BURST_EN
        exp_n = 2;
`else
        exp_n = 1;
`endif
        spi_frame(0, 0, 72, {56'h0, 8'h7F, 32'h1111_1111, 32'h2222_2222}, 0, 72, 1, rx);
        total++; if (wr_n - bw !== exp_n)      begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", wr_n - bw, exp_n); end
        total++; if (wa_q[b] !== 7'h7F)        begin bad++; $display("FAIL b2b_addr0 got=%h exp=7f", wa_q[b]); end
        total++; if (wd_q[b] !== 32'h11111111) begin bad++; $display("FAIL b2b_data0 got=%h exp=11111111", wd_q[b]); end
`ifdef HALF_DUPLEX_SPI_SLAVE_BURST_EN
        total++; if (wa_q[b+1] !== 7'h00)        begin bad++; $display("FAIL b2b_addr1 got=%h exp=00", wa_q[b+1]); end
        total++; if (wd_q[b+1] !== 32'h22222222) begin bad++; $display("FAIL b2b_data1 got=%h exp=22222222", wd_q[b+1]); end
`endif
        total++; if (both_n !== 0) begin bad++; $display("FAIL rd_wr_overlap got=%0d exp=0", both_n); end
    endtask

    initial begin
        test_reset();
        test_mode0_write();
        test_mode3_read();
        test_modes12();
        test_abort();
        test_reset_mid_read();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
